// File: rtl/regfile_wr_arbiter.sv
// Round-robin arbiter sharing the register-file write port between NREQ requesters.
// The winner is registered and presented to the register bank one cycle after the transfer.
module regfile_wr_arbiter #(
    parameter int NREQ         = 4,
    parameter int ADDR_W       = 5,
    parameter int DATA_W       = 32,
    parameter bit ZERO_PROTECT = 1'b1,
    localparam int SRC_W       = $clog2(NREQ),
    localparam int SEL_W       = 2**ADDR_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*ADDR_W-1:0]   req_addr,
    input  logic [NREQ*DATA_W-1:0]   req_data,
    output logic [NREQ-1:0]          req_ready,
    input  logic                     wr_stall,
    output logic                     wr_en,
    output logic [SEL_W-1:0]         wr_sel,
    output logic [ADDR_W-1:0]        wr_addr,
    output logic [DATA_W-1:0]        wr_data,
    output logic [SRC_W-1:0]         wr_src,
    output logic                     err_zero_wr
);

    // Handshake: requester i transfers on a rising edge where req_valid[i] && req_ready[i];
    // valid/addr/data are held stable until ready, and valid never waits on ready.

    logic [SRC_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [SRC_W-1:0]  gnt_idx;
    logic              gnt_any;
    logic [NREQ-1:0]   grant;
    int                idx;

    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_data;
    logic              zero_hit;

    logic              wr_en_q, wr_en_d;
    logic [SEL_W-1:0]  wr_sel_q, wr_sel_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic [SRC_W-1:0]  wr_src_q, wr_src_d;
    logic              err_q, err_d;

    // Search starts at rr_ptr and wraps; stall or reset blocks every grant.
    always_comb begin
        grant   = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        idx     = 0;
        if (rst_n && !wr_stall) begin
            for (int k = 0; k < NREQ; k++) begin
                idx = (int'(rr_ptr_q) + k) % NREQ;
                if (!gnt_any && req_valid[idx]) begin
                    gnt_any = 1'b1;
                    gnt_idx = SRC_W'(idx);
                end
            end
        end
        if (gnt_any) begin
            grant[gnt_idx] = 1'b1;
        end
    end

    assign req_ready = grant;

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (gnt_any) begin
            rr_ptr_d = (gnt_idx == SRC_W'(NREQ - 1)) ? '0 : gnt_idx + SRC_W'(1);
        end
    end

    always_comb begin
        win_addr = req_addr[int'(gnt_idx)*ADDR_W +: ADDR_W];
        win_data = req_data[int'(gnt_idx)*DATA_W +: DATA_W];
        zero_hit = gnt_any && ZERO_PROTECT && (win_addr == '0);

        wr_en_d   = gnt_any && !zero_hit;
        wr_sel_d  = wr_en_d ? (SEL_W'(1) << win_addr) : '0;
        err_d     = zero_hit;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        wr_src_d  = wr_src_q;
        // Suppressed register-0 writes still load the data path so wr_src names the offender.
        if (gnt_any) begin
            wr_addr_d = win_addr;
            wr_data_d = win_data;
            wr_src_d  = gnt_idx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q  <= '0;
            wr_en_q   <= 1'b0;
            wr_sel_q  <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            wr_src_q  <= '0;
            err_q     <= 1'b0;
        end else begin
            rr_ptr_q  <= rr_ptr_d;
            wr_en_q   <= wr_en_d;
            wr_sel_q  <= wr_sel_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            wr_src_q  <= wr_src_d;
            err_q     <= err_d;
        end
    end

    assign wr_en       = wr_en_q;
    assign wr_sel      = wr_sel_q;
    assign wr_addr     = wr_addr_q;
    assign wr_data     = wr_data_q;
    assign wr_src      = wr_src_q;
    assign err_zero_wr = err_q;

endmodule
